// File: rtl/cpu_pkg.sv
// Shared CPU-wide sizing constants and datapath typedefs.
package cpu_pkg;

    localparam int DATA_WIDTH              = 32;
    localparam int NUM_REGISTERS           = 32;
    localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);
    localparam int PENDING_WIDTH           = 2;

    typedef logic [REGISTER_INDEXING_WIDTH-1:0] reg_index_t;
    typedef logic [DATA_WIDTH-1:0]              data_t;

endpackage

// File: rtl/register_scoreboard.sv
// Per-register in-flight write counters: decode reservations increment, writeback retires.
module register_scoreboard #(
    parameter  int NUM_REGISTERS           = cpu_pkg::NUM_REGISTERS,
    parameter  int PENDING_WIDTH           = cpu_pkg::PENDING_WIDTH,
    localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register,
    input  logic                               write_activate,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] reserve_register,
    input  logic                               reserve_activate,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] query_register_a,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] query_register_b,
    output logic                               reserve_ready,
    output logic                               scoreboard_error,
    output logic                               clear_a,
    output logic                               clear_b
);

    localparam logic [PENDING_WIDTH-1:0] PENDING_ZERO = '0;
    localparam logic [PENDING_WIDTH-1:0] PENDING_ONE  = PENDING_WIDTH'(1);
    localparam logic [PENDING_WIDTH-1:0] PENDING_FULL = '1;

    logic [PENDING_WIDTH-1:0] pending [NUM_REGISTERS];
    logic                     write_hit;
    logic                     reserve_accept;
    logic                     write_to_reserved;

    assign write_hit         = write_activate && (write_register != '0);
    assign write_to_reserved = write_hit && (write_register == reserve_register);

    // A saturated counter can still take a reservation if a retire lands on it this cycle.
    assign reserve_ready = rst_n &&
                           ((reserve_register == '0) ||
                            (pending[reserve_register] != PENDING_FULL) ||
                            write_to_reserved);

    assign reserve_accept   = reserve_activate && reserve_ready && (reserve_register != '0);
    assign scoreboard_error = rst_n && write_hit && (pending[write_register] == PENDING_ZERO);

    always_comb begin
        clear_a = (pending[query_register_a] == PENDING_ZERO) ||
                  ((pending[query_register_a] == PENDING_ONE) && write_hit &&
                   (write_register == query_register_a));
        clear_b = (pending[query_register_b] == PENDING_ZERO) ||
                  ((pending[query_register_b] == PENDING_ONE) && write_hit &&
                   (write_register == query_register_b));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                pending[i] <= PENDING_ZERO;
            end
        end else begin
            for (int i = 1; i < NUM_REGISTERS; i++) begin
                // Retire and reserve on the same index cancel out.
                if (reserve_accept && (reserve_register == REGISTER_INDEXING_WIDTH'(i)) &&
                    !(write_hit && (write_register == REGISTER_INDEXING_WIDTH'(i)))) begin
                    pending[i] <= pending[i] + PENDING_ONE;
                end else if (write_hit && (write_register == REGISTER_INDEXING_WIDTH'(i)) &&
                             !(reserve_accept && (reserve_register == REGISTER_INDEXING_WIDTH'(i))) &&
                             (pending[i] != PENDING_ZERO)) begin
                    pending[i] <= pending[i] - PENDING_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with write bypass and RAW-hazard valid flags per read port.
module register_file #(
    parameter  int NUM_REGISTERS           = cpu_pkg::NUM_REGISTERS,
    parameter  int DATA_WIDTH              = cpu_pkg::DATA_WIDTH,
    parameter  int PENDING_WIDTH           = cpu_pkg::PENDING_WIDTH,
    localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register,
    input  logic [DATA_WIDTH-1:0]              write_data,
    input  logic                               write_activate,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] reserve_register,
    input  logic                               reserve_activate,
    output logic                               reserve_ready,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] read_register_a,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] read_register_b,
    output logic [DATA_WIDTH-1:0]              read_data_a,
    output logic [DATA_WIDTH-1:0]              read_data_b,
    output logic                               read_valid_a,
    output logic                               read_valid_b,
    output logic                               scoreboard_error
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGISTERS];
    logic                  write_hit;
    logic                  clear_a;
    logic                  clear_b;

    assign write_hit = write_activate && (write_register != '0);

    register_scoreboard #(
        .NUM_REGISTERS (NUM_REGISTERS),
        .PENDING_WIDTH (PENDING_WIDTH)
    ) u_scoreboard (
        .clk              (clk),
        .rst_n            (rst_n),
        .write_register   (write_register),
        .write_activate   (write_activate),
        .reserve_register (reserve_register),
        .reserve_activate (reserve_activate),
        .query_register_a (read_register_a),
        .query_register_b (read_register_b),
        .reserve_ready    (reserve_ready),
        .scoreboard_error (scoreboard_error),
        .clear_a          (clear_a),
        .clear_b          (clear_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[write_register] <= write_data;
        end
    end

    // Writeback data is forwarded so decode sees it in the same cycle it retires.
    always_comb begin
        read_data_a  = '0;
        read_data_b  = '0;
        read_valid_a = 1'b0;
        read_valid_b = 1'b0;
        if (rst_n) begin
            read_valid_a = clear_a;
            read_valid_b = clear_b;
            if (read_register_a != '0) begin
                read_data_a = (write_hit && (write_register == read_register_a)) ?
                              write_data : regs[read_register_a];
            end
            if (read_register_b != '0) begin
                read_data_b = (write_hit && (write_register == read_register_b)) ?
                              write_data : regs[read_register_b];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Randomized + directed bench for register_file with a queue-based scoreboard and abstract model.
module tb_register_file;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    reg_index_t write_register;
    data_t      write_data;
    logic       write_activate;
    reg_index_t reserve_register;
    logic       reserve_activate;
    logic       reserve_ready;
    reg_index_t read_register_a;
    reg_index_t read_register_b;
    data_t      read_data_a;
    data_t      read_data_b;
    logic       read_valid_a;
    logic       read_valid_b;
    logic       scoreboard_error;

    register_file dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .write_register   (write_register),
        .write_data       (write_data),
        .write_activate   (write_activate),
        .reserve_register (reserve_register),
        .reserve_activate (reserve_activate),
        .reserve_ready    (reserve_ready),
        .read_register_a  (read_register_a),
        .read_register_b  (read_register_b),
        .read_data_a      (read_data_a),
        .read_data_b      (read_data_b),
        .read_valid_a     (read_valid_a),
        .read_valid_b     (read_valid_b),
        .scoreboard_error (scoreboard_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data_a;
        logic [31:0] data_b;
        logic        valid_a;
        logic        valid_b;
        logic        ready;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_regs [32];
    int          model_pend [32];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // One cycle of stimulus: drive, predict outputs from pre-edge model state, then advance model.
    task automatic step(input logic rst, input logic wa, input int wreg, input logic [31:0] wdata,
                        input logic ra, input int rr, input int qa, input int qb);
        exp_t e;
        bit   w;
        bit   acc;
        @(posedge clk);
        #1;
        rst_n            = rst;
        write_activate   = wa;
        write_register   = reg_index_t'(wreg);
        write_data       = wdata;
        reserve_activate = ra;
        reserve_register = reg_index_t'(rr);
        read_register_a  = reg_index_t'(qa);
        read_register_b  = reg_index_t'(qb);

        w = wa && (wreg != 0);
        if (!rst) begin
            e = '{data_a: 32'h0, data_b: 32'h0, valid_a: 1'b0, valid_b: 1'b0, ready: 1'b0, err: 1'b0};
        end else begin
            e.data_a  = (qa == 0) ? 32'h0 : ((w && wreg == qa) ? wdata : model_regs[qa]);
            e.data_b  = (qb == 0) ? 32'h0 : ((w && wreg == qb) ? wdata : model_regs[qb]);
            e.valid_a = (model_pend[qa] - ((w && wreg == qa) ? 1 : 0)) <= 0;
            e.valid_b = (model_pend[qb] - ((w && wreg == qb) ? 1 : 0)) <= 0;
            e.ready   = (rr == 0) || (model_pend[rr] < 3) || (w && wreg == rr);
            e.err     = w && (model_pend[wreg] == 0);
        end
        exp_q.push_back(e);

        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                model_regs[i] = 32'h0;
                model_pend[i] = 0;
            end
        end else begin
            acc = ra && e.ready && (rr != 0);
            if (w) model_regs[wreg] = wdata;
            if (!(acc && w && rr == wreg)) begin
                if (w && model_pend[wreg] > 0) model_pend[wreg]--;
                if (acc) model_pend[rr]++;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #4;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("read_data_a",      read_data_a,            e.data_a);
                check("read_data_b",      read_data_b,            e.data_b);
                check("read_valid_a",     32'(read_valid_a),      32'(e.valid_a));
                check("read_valid_b",     32'(read_valid_b),      32'(e.valid_b));
                check("reserve_ready",    32'(reserve_ready),     32'(e.ready));
                check("scoreboard_error", 32'(scoreboard_error),  32'(e.err));
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0; write_activate = 1'b0; write_register = '0; write_data = '0;
        reserve_activate = 1'b0; reserve_register = '0; read_register_a = '0; read_register_b = '0;
        for (int i = 0; i < 32; i++) begin
            model_regs[i] = 32'h0;
            model_pend[i] = 0;
        end

        step(0, 0, 0, 0, 1, 5, 5, 0);
        step(0, 0, 0, 0, 1, 5, 5, 0);
        step(1, 0, 0, 0, 0, 5, 5, 0);
        step(1, 0, 0, 0, 1, 5, 5, 0);
        step(1, 0, 0, 0, 0, 0, 5, 0);
        step(1, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
        step(1, 0, 0, 0, 0, 0, 5, 0);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 1, 7, 7, 0);
        step(1, 1, 7, 32'h0000_0777, 1, 7, 7, 7);
        for (int k = 0; k < 3; k++) step(1, 1, 7, 32'h7000_0000 + k, 0, 0, 7, 0);
        step(1, 0, 0, 0, 0, 0, 7, 7);
        step(1, 1, 9, 32'h0000_0999, 0, 0, 9, 0);
        step(1, 0, 0, 0, 0, 0, 9, 9);
        step(1, 1, 0, 32'h0000_1234, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 9);
        step(1, 0, 0, 0, 1, 3, 3, 0);
        step(1, 0, 0, 0, 0, 0, 3, 0);
        step(0, 1, 3, 32'h5555_5555, 1, 3, 3, 0);
        step(1, 0, 0, 0, 0, 0, 3, 3);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 9) < 4, $urandom_range(0, 7), $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 31));
        end

        @(posedge clk);
        #6;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Architectural integer register file plus per-register pending-write scoreboard: the responder for the writeback stage's `write_register` / `write_data` / `write_activate` port. Decode reserves a destination register when it issues a writing instruction; writeback's write retires that reservation. Two read ports return data plus a valid flag that is low while a write to that register is still in flight, so decode stalls on RAW hazards.

## Interface
- `NUM_REGISTERS`, 32, architectural register count; index 0 hardwired to zero
- `DATA_WIDTH`, 32, register width
- `PENDING_WIDTH`, 2, per-register in-flight counter width (max 3 outstanding writes per register)
- `REGISTER_INDEXING_WIDTH`, $clog2(NUM_REGISTERS), derived, not overridable

Ports:
- `clk` in 1 — single clock, all state on posedge
- `rst_n` in 1 — synchronous, active-low reset
- `write_register` in REGISTER_INDEXING_WIDTH — writeback destination
- `write_data` in DATA_WIDTH — writeback value
- `write_activate` in 1 — write strobe; one write per cycle
- `reserve_register` in REGISTER_INDEXING_WIDTH — decode destination to mark pending
- `reserve_activate` in 1 — reservation request
- `reserve_ready` out 1 — reservation accepted this cycle when high with `reserve_activate`
- `read_register_a`, `read_register_b` in REGISTER_INDEXING_WIDTH — source indices
- `read_data_a`, `read_data_b` out DATA_WIDTH — combinational read data
- `read_valid_a`, `read_valid_b` out 1 — no unretired write pending for that source
- `scoreboard_error` out 1 — one-cycle pulse on write to a register with zero pending count

## Operation
- State: `regs[1..NUM_REGISTERS-1]`, `pending[1..NUM_REGISTERS-1]` (PENDING_WIDTH each); index 0 has no storage.
- Reset (rst_n low at posedge): all regs 0, all pending 0. While rst_n low: `reserve_ready`=0, `read_valid_*`=0, `read_data_*`=0, `scoreboard_error`=0; writes/reservations ignored.
- Write (`write_activate`, index≠0): regs updated at next edge; pending decremented unless already 0 (then no underflow, `scoreboard_error` pulses same cycle, data still written).
- Reserve: accepted when `reserve_activate && reserve_ready`; pending incremented at next edge. `reserve_ready` = 0 iff target pending is all-ones and no same-cycle write to it; reserving index 0 always ready, no effect.
- Same-cycle write and accepted reserve to same index: pending unchanged, data written.
- Index 0: reads return 0, valid 1; writes and reservations dropped, never error.
- Read, per port: if write_activate to same nonzero index this cycle → data = `write_data` (bypass); else data = `regs[idx]`. Valid = (pending_next_without_reserve == 0), i.e. pending==0, or pending==1 with a same-cycle write to it. Same-cycle reservation does not affect current-cycle read valid.

## Timing
- Read path fully combinational (inputs → read outputs, zero latency); write visible to reads same cycle via bypass, from array next cycle.
- Reservation affects `read_valid` from next cycle onward.
- `scoreboard_error` and `reserve_ready` combinational from current state and inputs.
- No backpressure on writes: writeback never stalls on this block.

## Structure
- Shared `cpu_pkg`: `DATA_WIDTH`, `NUM_REGISTERS`, `REGISTER_INDEXING_WIDTH`, `reg_index_t`, `data_t` typedefs.
- Sub-module `register_scoreboard`: pending counter array, reserve/retire arithmetic, `reserve_ready`, `scoreboard_error`, per-port pending-clear query. Data array and bypass muxing stay in `register_file`.

## Test plan
- Reset then read x5 and x0 → data 0, valid 1 for both; `reserve_ready`=0 during reset, 1 after.
- Reserve x5, next cycle read x5 → valid 0; write x5=0xDEADBEEF → same-cycle read valid 1, data 0xDEADBEEF; following cycle array read 0xDEADBEEF.
- Reserve x7 three times, fourth reserve → `reserve_ready`=0; same-cycle write x7 + reserve x7 → accepted, pending stays 3; three further writes → valid 1.
- Write x9 with pending 0 → `scoreboard_error` 1 for one cycle, x9 updated, pending 0.
- Write x0=0x1234 and reserve x0 → read x0 data 0 valid 1, no error.
- Reserve x3, assert rst_n low mid-flight for one cycle → afterwards x3 valid 1, data 0.
